// File: rtl/snake_step_scheduler.sv
// snake_step_scheduler: tick-paced snake step engine; shifts the body in an external RAM,
// moves the head, then scans the body for self-collision.
module snake_step_scheduler #(
  parameter int TICK_DIV = 1000000,
  parameter int MAX_LEN = 63,
  parameter int COORD_W = 11,
  parameter int BLOCK = 10,
  parameter int DISP_W = 136,
  parameter int DISP_H = 76
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         dir_in,
  input  logic               dir_valid,
  input  logic               grow,
  input  logic [COORD_W-1:0] body_rx,
  input  logic [COORD_W-1:0] body_ry,
  output logic [5:0]         body_raddr,
  output logic               body_we,
  output logic [5:0]         body_waddr,
  output logic [COORD_W-1:0] body_wx,
  output logic [COORD_W-1:0] body_wy,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [5:0]         length,
  output logic               busy,
  output logic               step_valid,
  output logic               game_over
);
  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam int FW = DISP_W * BLOCK;
  localparam int FH = DISP_H * BLOCK;
  localparam int X0 = (DISP_W / 2) * BLOCK;
  localparam int Y0 = (DISP_H / 2) * BLOCK;
  typedef enum logic [2:0] {INIT, IDLE, SH_RD, SH_WR, MOVE, SCAN, DONE, OVER} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic tick_pend_q, grow_pend_q, hit_q, game_over_q, step_valid_q;
  logic [1:0] cur_dir_q, dir_pend_q;
  logic [COORD_W-1:0] head_x_q, head_y_q, nx, ny, init_x;
  logic [COORD_W:0] xp, yp;
  logic [5:0] len_q, lnew_q, lnew_d, idx_q;
  logic tick, start, die, hit_d;
  always_comb begin
    tick = enable && cnt_q == CNT_W'(TICK_DIV - 1);
    start = state_q == IDLE && (tick || tick_pend_q);
    lnew_d = (grow_pend_q && len_q < 6'(MAX_LEN)) ? len_q + 6'd1 : len_q;
    xp = {1'b0, head_x_q} + (COORD_W+1)'(BLOCK);
    yp = {1'b0, head_y_q} + (COORD_W+1)'(BLOCK);
    die = (cur_dir_q == 2'd0) ? head_y_q == '0 :
          (cur_dir_q == 2'd1) ? xp >= (COORD_W+1)'(FW) :
          (cur_dir_q == 2'd2) ? yp >= (COORD_W+1)'(FH) : head_x_q == '0;
    nx = (cur_dir_q == 2'd1) ? xp[COORD_W-1:0] :
         (cur_dir_q == 2'd3) ? head_x_q - COORD_W'(BLOCK) : head_x_q;
    ny = (cur_dir_q == 2'd2) ? yp[COORD_W-1:0] :
         (cur_dir_q == 2'd0) ? head_y_q - COORD_W'(BLOCK) : head_y_q;
    // SCAN slot 0 only issues the first read; data compares start one slot later
    hit_d = hit_q || (idx_q != '0 && body_rx == head_x_q && body_ry == head_y_q);
    init_x = COORD_W'(X0 - int'(idx_q) * BLOCK);
  end
  assign body_we = reset && (state_q == INIT || state_q == SH_WR || (state_q == MOVE && !die));
  assign body_waddr = (state_q == MOVE) ? 6'd0 : idx_q;
  assign body_wx = (state_q == INIT) ? init_x : (state_q == SH_WR) ? body_rx : nx;
  assign body_wy = (state_q == INIT) ? COORD_W'(Y0) : (state_q == SH_WR) ? body_ry : ny;
  assign body_raddr = (state_q == SH_RD) ? idx_q - 6'd1 : (state_q == SCAN) ? idx_q + 6'd1 : 6'd0;
  assign busy = state_q != IDLE && state_q != OVER;
  assign head_x = head_x_q;
  assign head_y = head_y_q;
  assign length = len_q;
  assign step_valid = step_valid_q;
  assign game_over = game_over_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      tick_pend_q <= 1'b0;
      grow_pend_q <= 1'b0;
      cur_dir_q <= 2'd1;
      dir_pend_q <= 2'd1;
      head_x_q <= COORD_W'(X0);
      head_y_q <= COORD_W'(Y0);
      len_q <= 6'd3;
      lnew_q <= 6'd3;
      idx_q <= 6'd0;
      hit_q <= 1'b0;
      game_over_q <= 1'b0;
      step_valid_q <= 1'b0;
    end else begin
      cnt_q <= !enable ? cnt_q : tick ? '0 : cnt_q + CNT_W'(1);
      step_valid_q <= 1'b0;
      if (state_q != OVER) begin
        tick_pend_q <= !start && (tick_pend_q || tick);
        grow_pend_q <= (grow_pend_q && !start) || grow;
        if (dir_valid && dir_in != (cur_dir_q ^ 2'b10)) dir_pend_q <= dir_in;
      end
      case (state_q)
        INIT: begin
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd2) state_q <= IDLE;
        end
        IDLE: if (start) begin
          cur_dir_q <= dir_pend_q;
          lnew_q <= lnew_d;
          idx_q <= lnew_d - 6'd1;
          state_q <= (lnew_d > 6'd1) ? SH_RD : MOVE;
        end
        SH_RD: state_q <= SH_WR;
        SH_WR: begin
          idx_q <= idx_q - 6'd1;
          state_q <= (idx_q == 6'd1) ? MOVE : SH_RD;
        end
        MOVE: begin
          idx_q <= 6'd0;
          hit_q <= 1'b0;
          if (die) begin
            game_over_q <= 1'b1;
            state_q <= OVER;
          end else begin
            head_x_q <= nx;
            head_y_q <= ny;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 6'd1;
          hit_q <= hit_d;
          if (idx_q == lnew_q - 6'd1) begin
            if (hit_d) begin
              game_over_q <= 1'b1;
              state_q <= OVER;
            end else begin
              len_q <= lnew_q;
              step_valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        OVER: state_q <= OVER;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_step_scheduler.sv
// tb_snake_step_scheduler: directed steps against a 1-cycle-latency body RAM, TICK_DIV=4.
module tb_snake_step_scheduler;
  logic clk = 1'b0;
  logic reset, enable, dir_valid, grow;
  logic [1:0] dir_in;
  logic [10:0] body_rx, body_ry, body_wx, body_wy, head_x, head_y;
  logic [5:0] body_raddr, body_waddr, length;
  logic body_we, busy, step_valid, game_over;
  logic [21:0] mem [64];
  logic [21:0] rd;
  int n_chk = 0, n_fail = 0, wcnt = 0, w0cnt = 0, svcnt = 0;
  int c, w, s;

  snake_step_scheduler #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in), .dir_valid(dir_valid),
    .grow(grow), .body_rx(body_rx), .body_ry(body_ry), .body_raddr(body_raddr),
    .body_we(body_we), .body_waddr(body_waddr), .body_wx(body_wx), .body_wy(body_wy),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
    .step_valid(step_valid), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (body_we) begin
      mem[body_waddr] <= {body_wx, body_wy};
      wcnt <= wcnt + 1;
      if (body_waddr == 6'd0) w0cnt <= w0cnt + 1;
    end
    if (step_valid) svcnt <= svcnt + 1;
    rd <= mem[body_raddr];
  end
  assign {body_rx, body_ry} = rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_valid && n < 100);
  endtask

  task automatic pulse_dir(input logic [1:0] d, input logic g);
    dir_in = d;
    dir_valid = 1'b1;
    grow = g;
    @(negedge clk);
    dir_valid = 1'b0;
    grow = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; dir_in = 2'd0; dir_valid = 1'b0; grow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_head_x", head_x, 680);
    chk("rst_head_y", head_y, 380);
    chk("rst_length", length, 3);
    chk("rst_game_over", game_over, 0);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_body_we", body_we, 0);
    chk("rst_busy_init", busy, 1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("init_busy_done", busy, 0);
    chk("init_writes", wcnt, 3);
    chk("init_body0", mem[0], {11'd680, 11'd380});
    chk("init_body1", mem[1], {11'd670, 11'd380});
    chk("init_body2", mem[2], {11'd660, 11'd380});
    // basic stepping
    enable = 1'b1;
    wait_sv(c);
    chk("first_sv_latency", c, 12);
    chk("step1_head_x", head_x, 690);
    chk("step1_head_y", head_y, 380);
    chk("step1_length", length, 3);
    wait_sv(c);
    chk("step2_period", c, 10);
    chk("step2_head_x", head_x, 700);
    // reversal ignored, then turn up
    pulse_dir(2'd3, 1'b0);
    wait_sv(c);
    chk("rev_period", c, 9);
    chk("rev_head_x", head_x, 710);
    chk("rev_head_y", head_y, 380);
    pulse_dir(2'd0, 1'b0);
    wait_sv(c);
    chk("up_head_x", head_x, 710);
    chk("up_head_y", head_y, 370);
    // grow while turning right
    pulse_dir(2'd1, 1'b1);
    wait_sv(c);
    chk("grow4_period", c, 12);
    chk("grow4_length", length, 4);
    chk("grow4_head_x", head_x, 720);
    chk("grow4_body3", mem[3], {11'd700, 11'd380});
    chk("grow4_body2", mem[2], {11'd710, 11'd380});
    pulse_dir(2'd1, 1'b1);
    wait_sv(c);
    chk("grow5_period", c, 15);
    chk("grow5_length", length, 5);
    chk("grow5_head_x", head_x, 730);
    // up, left, down loop into the tail segment
    pulse_dir(2'd0, 1'b0);
    wait_sv(c);
    chk("loop_up_period", c, 15);
    chk("loop_up_head_y", head_y, 360);
    pulse_dir(2'd3, 1'b0);
    wait_sv(c);
    chk("loop_left_head_x", head_x, 720);
    chk("loop_left_head_y", head_y, 360);
    pulse_dir(2'd2, 1'b0);
    repeat (14) @(negedge clk);
    chk("coll_go_before", game_over, 0);
    @(negedge clk);
    chk("coll_go_after", game_over, 1);
    chk("coll_head_y", head_y, 370);
    chk("coll_length", length, 5);
    chk("coll_busy", busy, 0);
    s = svcnt;
    dir_in = 2'd2; dir_valid = 1'b1; grow = 1'b1;
    repeat (40) @(negedge clk);
    dir_valid = 1'b0; grow = 1'b0;
    chk("over_no_sv", svcnt - s, 0);
    chk("over_sticky", game_over, 1);
    chk("over_busy", busy, 0);
    chk("over_length", length, 5);
    // reset in the middle of a shift write
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("re_init_go", game_over, 0);
    enable = 1'b1;
    wait_sv(c);
    chk("re_step1_latency", c, 12);
    chk("re_step1_head_x", head_x, 690);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!body_we && c < 50);
    chk("shwr_delay", c, 3);
    chk("shwr_waddr", body_waddr, 2);
    reset = 1'b0; enable = 1'b0;
    #1;
    chk("mid_rst_we", body_we, 0);
    chk("mid_rst_head_x", head_x, 680);
    chk("mid_rst_length", length, 3);
    w = wcnt;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_init_writes", wcnt - w, 3);
    chk("mid_rst_body0", mem[0], {11'd680, 11'd380});
    chk("mid_rst_body1", mem[1], {11'd670, 11'd380});
    chk("mid_rst_body2", mem[2], {11'd660, 11'd380});
    chk("mid_rst_go", game_over, 0);
    s = svcnt; c = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) c++;
    end
    chk("mid_rst_no_pend_busy", c, 0);
    chk("mid_rst_no_pend_sv", svcnt - s, 0);
    // walk to the left wall and die
    pulse_dir(2'd0, 1'b0);
    enable = 1'b1;
    wait_sv(c);
    chk("wall_up_latency", c, 12);
    chk("wall_up_head_y", head_y, 370);
    pulse_dir(2'd3, 1'b0);
    wait_sv(c);
    chk("wall_left_period", c, 9);
    chk("wall_left_head_x", head_x, 670);
    repeat (67) wait_sv(c);
    chk("wall_edge_head_x", head_x, 0);
    chk("wall_edge_head_y", head_y, 370);
    w = w0cnt;
    repeat (6) @(negedge clk);
    chk("wall_go_before", game_over, 0);
    s = svcnt;
    @(negedge clk);
    chk("wall_go_after", game_over, 1);
    chk("wall_no_head_write", w0cnt - w, 0);
    chk("wall_head_x", head_x, 0);
    chk("wall_body0", mem[0], {11'd0, 11'd370});
    repeat (20) @(negedge clk);
    chk("wall_no_sv", svcnt - s, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_step_scheduler.md
SNAKE_STEP_SCHEDULER -- requirements
Module: snake_step_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk cycles per game step.
REQ-002 SHALL have parameter MAX_LEN, default 63, maximum snake length in segments.
REQ-003 SHALL have parameter COORD_W, default 11, coordinate width in bits.
REQ-004 SHALL have parameters BLOCK=10, DISP_W=136, DISP_H=76; the play field is DISP_W*BLOCK by DISP_H*BLOCK pixels.
REQ-005 SHALL have ports as follows:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- enable  input  1  game run; gates tick counter only.
- dir_in  input  2  requested direction: 00 up, 01 right, 10 down, 11 left.
- dir_valid  input  1  dir_in qualifier, sampled every cycle.
- grow  input  1  food-eaten pulse.
- body_rx, body_ry  input  COORD_W each  body RAM read data, 1-cycle latency after body_raddr.
- body_raddr  output  6  body RAM read address.
- body_we  output  1  body RAM write strobe.
- body_waddr  output  6  body RAM write address.
- body_wx, body_wy  output  COORD_W each  body RAM write data.
- head_x, head_y  output  COORD_W each  committed head position, in pixels.
- length  output  6  current segment count.
- busy  output  1  high in every state except IDLE and OVER.
- step_valid  output  1  one-cycle pulse when a step completes without death.
- game_over  output  1  sticky death flag.

Function
REQ-006 FSM states SHALL be INIT, IDLE, SH_RD, SH_WR, MOVE, SCAN, DONE and OVER.
REQ-007 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, hold while enable=0, and raise tick on the cycle it wraps to 0.
REQ-008 A tick arriving outside IDLE SHALL set tick_pend, a single flag; further ticks while it is set SHALL be dropped.
REQ-009 Direction filtering:
- A dir_valid cycle SHALL load dir_pend unless dir_in == cur_dir XOR 2'b10 (reversal).
- A reversal SHALL be ignored silently.
- The last accepted value SHALL win.
REQ-010 grow SHALL set grow_pend; grow_pend SHALL be consumed at step start.
REQ-011 Step start (IDLE with tick or tick_pend) SHALL:
- commit cur_dir <= dir_pend;
- set L_new = length+1 if grow_pend and length<MAX_LEN, else length;
- clear tick_pend and grow_pend.
REQ-012 Shift sequence for i = L_new-1 down to 1:
- SH_RD drives body_raddr=i-1.
- SH_WR writes body[i] = read data at waddr i.
- Total 2*(L_new-1) cycles.
REQ-013 MOVE SHALL compute the new head as follows:
- up: y-BLOCK; down: y+BLOCK; right: x+BLOCK; left: x-BLOCK.
- If in bounds, write it to body[0] and update head_x/head_y.
REQ-014 Bounds rule: any of the following SHALL go to OVER with no write:
- up with y==0;
- left with x==0;
- right with x+BLOCK >= DISP_W*BLOCK;
- down with y+BLOCK >= DISP_H*BLOCK.
REQ-015 SCAN SHALL read addresses 1..L_new-1, one per cycle, and compare each returned entry with the new head one cycle later; SCAN SHALL last L_new cycles.
REQ-016 On any SCAN match, SCAN SHALL finish and then go to OVER; otherwise it SHALL go to DONE.
REQ-017 In DONE, length SHALL be updated to L_new and step_valid SHALL pulse; the FSM SHALL then return to IDLE.
REQ-018 step_valid SHALL assert exactly 3*L_new cycles after the step-start cycle.
REQ-019 OVER SHALL set game_over=1 and remain in OVER until reset; ticks, dir_valid and grow SHALL be ignored in OVER.
REQ-020 At most one body RAM write SHALL occur per cycle; body_we SHALL be 0 in IDLE, SH_RD, SCAN, DONE and OVER.
REQ-021 enable=0 mid-step SHALL NOT stall the FSM; the step in progress SHALL complete.

Reset
REQ-022 While reset=0, the block SHALL hold:
- FSM = INIT; counter = 0;
- head = (680,380); cur_dir = dir_pend = right; length = 3;
- tick_pend = grow_pend = 0;
- all strobes and game_over = 0.
REQ-023 INIT SHALL write body[0..2] = (680,380), (670,380), (660,380) over 3 cycles and then enter IDLE; busy SHALL be 1 during INIT.
REQ-024 Reset asserted mid-step SHALL abort the step immediately; no partial state SHALL survive.

Verification
REQ-025 TICK_DIV=4, enable=1, no input -> step_valid 9 cycles after each step start; head (690,380), then (700,380); length 3.
REQ-026 With cur_dir right, dir_in=11 with dir_valid -> ignored, head moves right; dir_in=00 -> next head (x,370).
REQ-027 grow pulse, then tick -> L_new=4; 6 shift cycles; step_valid at +12; length 4; body[3] = old body[2].
REQ-028 Head (0,380), dir left, tick -> OVER after MOVE; game_over=1; no body_we in MOVE; step_valid never pulses.
REQ-029 Long-body loop (up, left, down) driving the head into body[k] -> game_over at end of SCAN; later ticks ignored.
REQ-030 Reset pulsed during SH_WR -> INIT writes 3 entries; head (680,380); length 3; game_over=0.
